// File: rtl/irrigation_display.sv
// irrigation_display: 4-digit multiplexed seven-segment display stage for the
// irrigation controller. Shows tank level, inlet valve, irrigation mode and
// cleaning register. Inputs are captured once per frame. An empty tank while
// irrigating raises an alarm that blinks the whole display.
module irrigation_display #(
  parameter int unsigned SCAN_DIV     = 1000,
  parameter int unsigned BLINK_FRAMES = 64
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [2:0] nivel,
  input  logic       ve,
  input  logic [1:0] modo,
  input  logic [1:0] limpeza,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic       dp
);

  localparam int unsigned PW = $clog2(SCAN_DIV);
  localparam int unsigned FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(SCAN_DIV - 1);
  localparam logic [FW-1:0] FRM_LAST = FW'(BLINK_FRAMES - 1);

  // Glyphs as {g,f,e,d,c,b,a}, active-low
  localparam logic [6:0] GL_0    = 7'b1000000;
  localparam logic [6:0] GL_1    = 7'b1111001;
  localparam logic [6:0] GL_2    = 7'b0100100;
  localparam logic [6:0] GL_3    = 7'b0110000;
  localparam logic [6:0] GL_A    = 7'b0001000;
  localparam logic [6:0] GL_F    = 7'b0001110;
  localparam logic [6:0] GL_G    = 7'b1000010;
  localparam logic [6:0] GL_E    = 7'b0000110;
  localparam logic [6:0] GL_DASH = 7'b0111111;
  localparam logic [6:0] GL_OFF  = 7'b1111111;

  typedef enum logic {
    PH_VISIBLE = 1'b0,
    PH_BLANK   = 1'b1
  } phase_e;

  logic [PW-1:0] pre_q, pre_d;
  logic [1:0]    dig_q, dig_d;
  logic [2:0]    snap_nivel_q, snap_nivel_d;
  logic          snap_ve_q, snap_ve_d;
  logic [1:0]    snap_modo_q, snap_modo_d;
  logic [1:0]    snap_limp_q, snap_limp_d;
  logic [FW-1:0] frm_q, frm_d;
  phase_e        phase_q, phase_d;
  logic [6:0]    seg_q, seg_d;
  logic [3:0]    an_q, an_d;
  logic          dp_q, dp_d;

  logic tick;
  logic frame_end;
  logic alarm;

  function automatic logic [6:0] digit_glyph(input logic [1:0] v);
    logic [6:0] g;
    case (v)
      2'd0:    g = GL_0;
      2'd1:    g = GL_1;
      2'd2:    g = GL_2;
      default: g = GL_3;
    endcase
    return g;
  endfunction

  assign tick      = (pre_q == PRE_LAST);
  assign frame_end = tick && (dig_q == 2'd3);
  assign alarm     = (snap_nivel_q == 3'b000) &&
                     ((snap_modo_q == 2'b01) || (snap_modo_q == 2'b10));

  // Prescaler and digit index
  always_comb begin
    pre_d = pre_q + PW'(1);
    dig_d = dig_q;
    if (tick) begin
      pre_d = '0;
      dig_d = dig_q + 2'd1;
    end
  end

  // Per-frame input snapshot
  always_comb begin
    snap_nivel_d = snap_nivel_q;
    snap_ve_d    = snap_ve_q;
    snap_modo_d  = snap_modo_q;
    snap_limp_d  = snap_limp_q;
    if (frame_end) begin
      snap_nivel_d = nivel;
      snap_ve_d    = ve;
      snap_modo_d  = modo;
      snap_limp_d  = limpeza;
    end
  end

  // Blink frame counter and phase; idle and visible whenever the alarm is off
  always_comb begin
    frm_d   = frm_q;
    phase_d = phase_q;
    if (!alarm) begin
      frm_d   = '0;
      phase_d = PH_VISIBLE;
    end else if (frame_end) begin
      if (frm_q == FRM_LAST) begin
        frm_d   = '0;
        phase_d = (phase_q == PH_VISIBLE) ? PH_BLANK : PH_VISIBLE;
      end else begin
        frm_d = frm_q + FW'(1);
      end
    end
  end

  // Digit content decode; blanking is gated by the live alarm so that the
  // frame after an alarm-clearing snapshot is never blank, even though the
  // phase register only returns to visible one cycle later.
  always_comb begin
    seg_d = GL_DASH;
    an_d  = '1;
    dp_d  = 1'b1;
    case (dig_q)
      2'd0: begin
        an_d = 4'b1110;
        case (snap_nivel_q)
          3'b000:  seg_d = GL_0;
          3'b001:  seg_d = GL_1;
          3'b011:  seg_d = GL_2;
          3'b111:  seg_d = GL_3;
          default: seg_d = GL_DASH;
        endcase
      end
      2'd1: begin
        an_d  = 4'b1101;
        seg_d = snap_ve_q ? GL_A : GL_F;
      end
      2'd2: begin
        an_d = 4'b1011;
        case (snap_modo_q)
          2'b00:   seg_d = GL_DASH;
          2'b01:   seg_d = GL_A;
          2'b10:   seg_d = GL_G;
          default: seg_d = GL_E;
        endcase
      end
      default: begin
        an_d  = 4'b0111;
        seg_d = digit_glyph(snap_limp_q);
        dp_d  = !alarm;
      end
    endcase
    if (alarm && (phase_q == PH_BLANK)) begin
      seg_d = GL_OFF;
      an_d  = '1;
      dp_d  = 1'b1;
    end
  end

  // State and output registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pre_q        <= '0;
      dig_q        <= '0;
      snap_nivel_q <= '0;
      snap_ve_q    <= 1'b0;
      snap_modo_q  <= '0;
      snap_limp_q  <= '0;
      frm_q        <= '0;
      phase_q      <= PH_VISIBLE;
      seg_q        <= '1;
      an_q         <= '1;
      dp_q         <= 1'b1;
    end else begin
      pre_q        <= pre_d;
      dig_q        <= dig_d;
      snap_nivel_q <= snap_nivel_d;
      snap_ve_q    <= snap_ve_d;
      snap_modo_q  <= snap_modo_d;
      snap_limp_q  <= snap_limp_d;
      frm_q        <= frm_d;
      phase_q      <= phase_d;
      seg_q        <= seg_d;
      an_q         <= an_d;
      dp_q         <= dp_d;
    end
  end

  assign seg = seg_q;
  assign an  = an_q;
  assign dp  = dp_q;

endmodule

// File: tb/tb_irrigation_display.sv
// Bench for irrigation_display: a frame-level model (cycle count, per-frame
// snapshot, alarm run length) checks the outputs every cycle, and directed
// steps pin specific displayed values with literals.
module tb_irrigation_display;

  localparam int SD = 4;
  localparam int BF = 2;
  localparam int FRAME = 4 * SD;

  logic       clock;
  logic       reset;
  logic [2:0] nivel;
  logic       ve;
  logic [1:0] modo;
  logic [1:0] limpeza;
  logic [6:0] seg;
  logic [3:0] an;
  logic       dp;

  int errors = 0;
  int checks = 0;

  irrigation_display #(.SCAN_DIV(SD), .BLINK_FRAMES(BF)) dut (
    .clock   (clock),
    .reset   (reset),
    .nivel   (nivel),
    .ve      (ve),
    .modo    (modo),
    .limpeza (limpeza),
    .seg     (seg),
    .an      (an),
    .dp      (dp)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: glyph lookups straight from the display tables
  function automatic logic [6:0] num_glyph(input int v);
    case (v)
      0:       return 7'b1000000;
      1:       return 7'b1111001;
      2:       return 7'b0100100;
      3:       return 7'b0110000;
      default: return 7'b0111111;
    endcase
  endfunction

  function automatic int level_count(input logic [2:0] n);
    case (n)
      3'b000:  return 0;
      3'b001:  return 1;
      3'b011:  return 2;
      3'b111:  return 3;
      default: return -1;
    endcase
  endfunction

  // Model state: k = clock edges since reset release (edge k shows slot
  // (k-1)/SD), snapshot for the current frame, and run = index of the
  // current frame within an unbroken run of alarm frames.
  int         k = 0;
  logic [2:0] m_niv;
  logic       m_ve;
  logic [1:0] m_modo, m_limp;
  int         run;

  always @(posedge clock) begin
    logic [3:0] e_an;
    logic [6:0] e_seg;
    logic       e_dp;
    logic       al, al_new;
    int         d;
    if (!reset) begin
      k = 0; m_niv = '0; m_ve = 1'b0; m_modo = '0; m_limp = '0; run = 0;
      e_an = 4'b1111; e_seg = 7'b1111111; e_dp = 1'b1;
    end else begin
      k++;
      d  = ((k - 1) / SD) % 4;
      al = (m_niv == 3'b000) && (m_modo == 2'b01 || m_modo == 2'b10);
      e_dp = 1'b1;
      case (d)
        0: begin e_an = 4'b1110; e_seg = num_glyph(level_count(m_niv)); end
        1: begin e_an = 4'b1101; e_seg = m_ve ? 7'b0001000 : 7'b0001110; end
        2: begin
          e_an = 4'b1011;
          e_seg = (m_modo == 2'b00) ? 7'b0111111 :
                  (m_modo == 2'b01) ? 7'b0001000 :
                  (m_modo == 2'b10) ? 7'b1000010 : 7'b0000110;
        end
        default: begin e_an = 4'b0111; e_seg = num_glyph(int'(m_limp)); e_dp = !al; end
      endcase
      if (al && ((run / BF) % 2 == 1)) begin
        e_an = 4'b1111; e_seg = 7'b1111111; e_dp = 1'b1;
      end
      if (k % FRAME == 0) begin
        al_new = (nivel == 3'b000) && (modo == 2'b01 || modo == 2'b10);
        run    = al_new ? (al ? run + 1 : 0) : 0;
        m_niv = nivel; m_ve = ve; m_modo = modo; m_limp = limpeza;
      end
    end
    #1;
    check("model_an", {4'b0, an}, {4'b0, e_an});
    check("model_seg", {1'b0, seg}, {1'b0, e_seg});
    check("model_dp", {7'b0, dp}, {7'b0, e_dp});
  end

  task automatic goto(input int t);
    while (k < t) @(negedge clock);
  endtask

  task automatic pin(input string name, input logic [3:0] x_an, input logic [6:0] x_seg, input logic x_dp);
    check({name, "_an"}, {4'b0, an}, {4'b0, x_an});
    check({name, "_seg"}, {1'b0, seg}, {1'b0, x_seg});
    check({name, "_dp"}, {7'b0, dp}, {7'b0, x_dp});
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

  logic [3:0] an_tbl [4];
  logic [6:0] seg_tbl [4];

  initial begin
    an_tbl  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    seg_tbl = '{7'b1000000, 7'b0001110, 7'b0111111, 7'b1000000};
    reset = 1'b0; nivel = '0; ve = 1'b0; modo = '0; limpeza = '0;
    repeat (3) @(negedge clock);
    pin("reset", 4'b1111, 7'b1111111, 1'b1);
    reset = 1'b1;

    // "0F-0" after release, each digit for SD cycles
    for (int i = 1; i <= FRAME; i++) begin
      @(negedge clock);
      pin("scan0", an_tbl[(i - 1) / SD], seg_tbl[(i - 1) / SD], 1'b1);
    end

    // Mid-frame change held until the boundary, then 3/A/G/2
    goto(21);
    nivel = 3'b111; ve = 1'b1; modo = 2'b10; limpeza = 2'd2;
    goto(29); pin("hold", 4'b0111, 7'b1000000, 1'b1);
    goto(33); pin("new_d0", 4'b1110, 7'b0110000, 1'b1);
    goto(37); pin("new_d1", 4'b1101, 7'b0001000, 1'b1);
    goto(41); pin("new_d2", 4'b1011, 7'b1000010, 1'b1);
    goto(45); pin("new_d3", 4'b0111, 7'b0100100, 1'b1);

    // Invalid level code: dash, no alarm
    goto(50);
    nivel = 3'b010; ve = 1'b0; modo = 2'b01; limpeza = 2'd1;
    goto(65); pin("inv_d0", 4'b1110, 7'b0111111, 1'b1);
    goto(73); pin("inv_d2", 4'b1011, 7'b0001000, 1'b1);
    goto(77); pin("inv_d3", 4'b0111, 7'b1111001, 1'b1);

    // Empty tank while sprinkling: 2 visible frames, 2 blank, repeat
    goto(82);
    nivel = 3'b000; modo = 2'b01; limpeza = 2'd0;
    goto(109); pin("alarm_dp", 4'b0111, 7'b1000000, 1'b0);
    goto(129); pin("blank1", 4'b1111, 7'b1111111, 1'b1);
    goto(145); pin("blank2", 4'b1111, 7'b1111111, 1'b1);
    goto(161); pin("visible_again", 4'b1110, 7'b1000000, 1'b1);

    // Clear alarm during a blank frame, then re-arm: counter restarts
    goto(195);
    pin("blank3", 4'b1111, 7'b1111111, 1'b1);
    modo = 2'b00;
    goto(209); pin("cleared", 4'b1110, 7'b1000000, 1'b1);
    goto(215); modo = 2'b01;
    goto(221); pin("cleared_dp", 4'b0111, 7'b1000000, 1'b1);
    goto(241); pin("rearm_vis", 4'b1110, 7'b1000000, 1'b1);
    goto(257); pin("rearm_blank", 4'b1111, 7'b1111111, 1'b1);

    // Async reset on cycle 3 of digit 2
    goto(260); modo = 2'b00;
    goto(283); pin("pre_reset", 4'b1011, 7'b0111111, 1'b1);
    nivel = 3'b111; ve = 1'b1; modo = 2'b10; limpeza = 2'd3;
    reset = 1'b0;
    #1 pin("async_reset", 4'b1111, 7'b1111111, 1'b1);
    repeat (3) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    pin("post_reset_d0", 4'b1110, 7'b1000000, 1'b1);
    goto(5);  pin("post_reset_d1", 4'b1101, 7'b0001110, 1'b1);
    goto(17); pin("post_load_d0", 4'b1110, 7'b0110000, 1'b1);
    goto(29); pin("post_load_d3", 4'b0111, 7'b0110000, 1'b1);
    @(negedge clock);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
